// File: rtl/cmi_xfer_seq.sv
// CMI transfer sequencer: arbitrates for the CMI, drives the address and write-data
// phases via the MDR driver enable, then waits for slave status. On a read it strobes
// the MDR read-data latch once per ACK. Finishes with a one-cycle done/error pulse.
//
// Optional feature: define CMI_XFER_TIMEOUT_EN to enable the WAIT-state timeout
// counter (limit TMO_MAX). Without it WAIT holds until status arrives and tmo_h is 0.
module cmi_xfer_seq #(
  parameter int unsigned TMO_MAX = 31
) (
  input  logic       b_clk_l,
  input  logic       reset_l,
  input  logic       req_h,
  input  logic       wr_h,
  input  logic [1:0] len_h,
  input  logic       cmi_grant_l,
  input  logic       cmi_busy_l,
  input  logic [1:0] cmi_stat_h,
  output logic       cmi_req_l,
  output logic       ena_cmi_l,
  output logic       snapshot_cmi_l,
  output logic       busy_h,
  output logic       done_h,
  output logic       err_h,
  output logic       tmo_h,
  output logic [1:0] wcnt_h
);

  // The timeout counter is 5 bits wide, so the limit must fit in 1..31.
  if (TMO_MAX < 1 || TMO_MAX > 31) begin : g_tmo_max_range
    $error("cmi_xfer_seq: TMO_MAX must be in 1..31");
  end

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StAddr,
    StWdata,
    StWait,
    StDone,
    StErr
  } state_e;

  localparam logic [1:0] StatAck = 2'b01;

  state_e     state;
  logic       wr_lat;   // transfer direction captured at request time
  logic [1:0] len_lat;  // word count minus one captured at request time

`ifdef CMI_XFER_TIMEOUT_EN
  // Counter value seen in the last WAIT cycle before the timeout fires.
  localparam logic [4:0] TmoLast = 5'(TMO_MAX - 1);
  logic [4:0] tmo_cnt;
`else
  assign tmo_h = 1'b0;
`endif

  // Single-process state machine; every output is a flop updated alongside the state
  // so its value is valid for the whole cycle spent in the new state.
  always_ff @(posedge b_clk_l or negedge reset_l) begin
    if (!reset_l) begin
      state          <= StIdle;
      wr_lat         <= 1'b0;
      len_lat        <= 2'd0;
      cmi_req_l      <= 1'b1;
      ena_cmi_l      <= 1'b1;
      snapshot_cmi_l <= 1'b1;
      busy_h         <= 1'b0;
      done_h         <= 1'b0;
      err_h          <= 1'b0;
      wcnt_h         <= 2'd0;
`ifdef CMI_XFER_TIMEOUT_EN
      tmo_h          <= 1'b0;
      tmo_cnt        <= 5'd0;
`endif
    end else begin
      // Pulse outputs default to inactive each cycle.
      snapshot_cmi_l <= 1'b1;
      done_h         <= 1'b0;
      err_h          <= 1'b0;
`ifdef CMI_XFER_TIMEOUT_EN
      tmo_h          <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          if (req_h) begin
            wr_lat    <= wr_h;
            len_lat   <= len_h;
            wcnt_h    <= len_h;
            busy_h    <= 1'b1;
            cmi_req_l <= 1'b0;
            state     <= StArb;
          end
        end

        StArb: begin
          // A grant only counts while nobody else holds the bus.
          if (!cmi_grant_l && cmi_busy_l) begin
            ena_cmi_l <= 1'b0;
            state     <= StAddr;
          end
        end

        StAddr: begin
          if (wr_lat) begin
            state <= StWdata;
          end else begin
            cmi_req_l <= 1'b1;
            ena_cmi_l <= 1'b1;
            wcnt_h    <= len_lat;
`ifdef CMI_XFER_TIMEOUT_EN
            tmo_cnt   <= 5'd0;
`endif
            state     <= StWait;
          end
        end

        StWdata: begin
          // One data word per cycle; leave after the word with wcnt_h == 0.
          if (wcnt_h == 2'd0) begin
            cmi_req_l <= 1'b1;
            ena_cmi_l <= 1'b1;
`ifdef CMI_XFER_TIMEOUT_EN
            tmo_cnt   <= 5'd0;
`endif
            state     <= StWait;
          end else begin
            wcnt_h <= wcnt_h - 2'd1;
          end
        end

        StWait: begin
          // Error and reserved status take priority over any ACK, including the last.
          if (cmi_stat_h[1]) begin
            done_h <= 1'b1;
            err_h  <= 1'b1;
            state  <= StErr;
          end else if (cmi_stat_h == StatAck) begin
            if (wr_lat) begin
              done_h <= 1'b1;
              state  <= StDone;
            end else begin
              snapshot_cmi_l <= 1'b0;
              if (wcnt_h == 2'd0) begin
                done_h <= 1'b1;
                state  <= StDone;
              end else begin
                wcnt_h <= wcnt_h - 2'd1;
`ifdef CMI_XFER_TIMEOUT_EN
                tmo_cnt <= 5'd0;
`endif
              end
            end
          end
`ifdef CMI_XFER_TIMEOUT_EN
          else if (tmo_cnt == TmoLast) begin
            done_h <= 1'b1;
            err_h  <= 1'b1;
            tmo_h  <= 1'b1;
            state  <= StErr;
          end else begin
            tmo_cnt <= tmo_cnt + 5'd1;
          end
`endif
        end

        StDone, StErr: begin
          busy_h <= 1'b0;
          state  <= StIdle;
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmi_xfer_seq.sv
// Bench for cmi_xfer_seq: table of per-cycle stimulus with expected outputs, plus
// hand-written sequences for the WAIT hold/timeout and asynchronous reset cases.
module tb_cmi_xfer_seq;

  localparam int unsigned TMO = 31;

  logic       b_clk_l = 1'b0;
  logic       reset_l = 1'b0;
  logic       req_h = 1'b0;
  logic       wr_h = 1'b0;
  logic [1:0] len_h = 2'd0;
  logic       cmi_grant_l = 1'b1;
  logic       cmi_busy_l = 1'b1;
  logic [1:0] cmi_stat_h = 2'd0;
  logic       cmi_req_l;
  logic       ena_cmi_l;
  logic       snapshot_cmi_l;
  logic       busy_h;
  logic       done_h;
  logic       err_h;
  logic       tmo_h;
  logic [1:0] wcnt_h;
  logic [8:0] obs;

  always #5 b_clk_l = ~b_clk_l;

  cmi_xfer_seq #(.TMO_MAX(TMO)) dut (
    .b_clk_l        (b_clk_l),
    .reset_l        (reset_l),
    .req_h          (req_h),
    .wr_h           (wr_h),
    .len_h          (len_h),
    .cmi_grant_l    (cmi_grant_l),
    .cmi_busy_l     (cmi_busy_l),
    .cmi_stat_h     (cmi_stat_h),
    .cmi_req_l      (cmi_req_l),
    .ena_cmi_l      (ena_cmi_l),
    .snapshot_cmi_l (snapshot_cmi_l),
    .busy_h         (busy_h),
    .done_h         (done_h),
    .err_h          (err_h),
    .tmo_h          (tmo_h),
    .wcnt_h         (wcnt_h)
  );

  // {cmi_req_l, ena_cmi_l, snapshot_cmi_l, busy_h, done_h, err_h, tmo_h, wcnt_h}
  assign obs = {cmi_req_l, ena_cmi_l, snapshot_cmi_l, busy_h, done_h, err_h, tmo_h, wcnt_h};

  typedef struct {
    string      name;
    logic       req;
    logic       wr;
    logic [1:0] len;
    logic       gnt_l;
    logic       bsy_l;
    logic [1:0] stat;
    logic [8:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [8:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [8:0] o(input logic rq_l, input logic en_l, input logic sn_l,
                                   input logic bs, input logic dn, input logic er,
                                   input logic tm, input logic [1:0] wc);
    return {rq_l, en_l, sn_l, bs, dn, er, tm, wc};
  endfunction

  function automatic void add(input string name, input logic req, input logic wr,
                              input logic [1:0] len, input logic gnt_l, input logic bsy_l,
                              input logic [1:0] stat, input logic [8:0] exp);
    vec_t v;
    v.name = name; v.req = req; v.wr = wr; v.len = len;
    v.gnt_l = gnt_l; v.bsy_l = bsy_l; v.stat = stat; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (req_l ena_l snap_l busy done err tmo wcnt[1:0])",
               name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    sb_t e;
    req_h = v.req; wr_h = v.wr; len_h = v.len;
    cmi_grant_l = v.gnt_l; cmi_busy_l = v.bsy_l; cmi_stat_h = v.stat;
    e.name = v.name; e.exp = v.exp;
    sb.push_back(e);
    @(posedge b_clk_l);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty, got %b expected an entry", v.name, obs);
    end else begin
      e = sb.pop_front();
      check(e.name, obs, e.exp);
    end
  endtask

  task automatic step(input string name, input logic req, input logic wr, input logic [1:0] len,
                      input logic gnt_l, input logic bsy_l, input logic [1:0] stat,
                      input logic [8:0] exp);
    vec_t v;
    v.name = name; v.req = req; v.wr = wr; v.len = len;
    v.gnt_l = gnt_l; v.bsy_l = bsy_l; v.stat = stat; v.exp = exp;
    apply(v);
  endtask

  logic [8:0] rst_o;
  logic [8:0] idle_o;
  logic [8:0] wait_o;

  initial begin
    rst_o  = o(1, 1, 1, 0, 0, 0, 0, 2'd0);
    idle_o = o(1, 1, 1, 0, 0, 0, 0, 2'd0);

    // Write, len 0, grant on 2nd ARB cycle, ACK on 3rd WAIT cycle.
    add("a_req",   1, 1, 2'd0, 1, 1, 2'd0, o(0, 1, 1, 1, 0, 0, 0, 2'd0));
    add("a_arb1",  0, 0, 2'd0, 1, 1, 2'd0, o(0, 1, 1, 1, 0, 0, 0, 2'd0));
    add("a_gnt",   0, 0, 2'd0, 0, 1, 2'd0, o(0, 0, 1, 1, 0, 0, 0, 2'd0));
    add("a_wdata", 0, 0, 2'd0, 1, 1, 2'd0, o(0, 0, 1, 1, 0, 0, 0, 2'd0));
    add("a_wait1", 0, 0, 2'd0, 1, 1, 2'd0, o(1, 1, 1, 1, 0, 0, 0, 2'd0));
    add("a_wait2", 0, 0, 2'd0, 1, 1, 2'd0, o(1, 1, 1, 1, 0, 0, 0, 2'd0));
    add("a_wait3", 0, 0, 2'd0, 1, 1, 2'd0, o(1, 1, 1, 1, 0, 0, 0, 2'd0));
    add("a_ack",   0, 0, 2'd0, 1, 1, 2'd1, o(1, 1, 1, 1, 1, 0, 0, 2'd0));
    add("a_idle",  0, 0, 2'd0, 1, 1, 2'd0, idle_o);

    // Read, len 3, ACK gaps 0/2/0/5; extra ACKs afterwards are ignored.
    add("b_req",   1, 0, 2'd3, 1, 1, 2'd0, o(0, 1, 1, 1, 0, 0, 0, 2'd3));
    add("b_gnt",   0, 0, 2'd0, 0, 1, 2'd0, o(0, 0, 1, 1, 0, 0, 0, 2'd3));
    add("b_addr",  0, 0, 2'd0, 1, 1, 2'd0, o(1, 1, 1, 1, 0, 0, 0, 2'd3));
    add("b_ack1",  0, 0, 2'd0, 1, 1, 2'd1, o(1, 1, 0, 1, 0, 0, 0, 2'd2));
    add("b_gap2a", 0, 0, 2'd0, 1, 1, 2'd0, o(1, 1, 1, 1, 0, 0, 0, 2'd2));
    add("b_gap2b", 0, 0, 2'd0, 1, 1, 2'd0, o(1, 1, 1, 1, 0, 0, 0, 2'd2));
    add("b_ack2",  0, 0, 2'd0, 1, 1, 2'd1, o(1, 1, 0, 1, 0, 0, 0, 2'd1));
    add("b_ack3",  0, 0, 2'd0, 1, 1, 2'd1, o(1, 1, 0, 1, 0, 0, 0, 2'd0));
    for (int i = 0; i < 5; i++) begin
      add($sformatf("b_gap4_%0d", i), 0, 0, 2'd0, 1, 1, 2'd0, o(1, 1, 1, 1, 0, 0, 0, 2'd0));
    end
    add("b_ack4",  0, 0, 2'd0, 1, 1, 2'd1, o(1, 1, 0, 1, 1, 0, 0, 2'd0));
    add("b_xack1", 0, 0, 2'd0, 1, 1, 2'd1, idle_o);
    add("b_xack2", 0, 0, 2'd0, 1, 1, 2'd1, idle_o);

    // Write, len 1, grant held while the bus is busy for 4 cycles.
    add("c_req",   1, 1, 2'd1, 1, 1, 2'd0, o(0, 1, 1, 1, 0, 0, 0, 2'd1));
    for (int i = 0; i < 4; i++) begin
      add($sformatf("c_busy%0d", i), 0, 0, 2'd0, 0, 0, 2'd0, o(0, 1, 1, 1, 0, 0, 0, 2'd1));
    end
    add("c_gnt",   0, 0, 2'd0, 0, 1, 2'd0, o(0, 0, 1, 1, 0, 0, 0, 2'd1));
    add("c_wd1",   0, 0, 2'd0, 1, 1, 2'd0, o(0, 0, 1, 1, 0, 0, 0, 2'd1));
    add("c_wd2",   0, 0, 2'd0, 1, 1, 2'd0, o(0, 0, 1, 1, 0, 0, 0, 2'd0));
    add("c_wait",  0, 0, 2'd0, 1, 1, 2'd0, o(1, 1, 1, 1, 0, 0, 0, 2'd0));
    add("c_ack",   0, 0, 2'd0, 1, 1, 2'd1, o(1, 1, 1, 1, 1, 0, 0, 2'd0));
    add("c_idle",  0, 0, 2'd0, 1, 1, 2'd0, idle_o);

    // Write, len 2, error status in WAIT; a stray req_h mid-transfer is ignored.
    add("d_req",   1, 1, 2'd2, 1, 1, 2'd0, o(0, 1, 1, 1, 0, 0, 0, 2'd2));
    add("d_gnt",   0, 0, 2'd0, 0, 1, 2'd0, o(0, 0, 1, 1, 0, 0, 0, 2'd2));
    add("d_wd1",   0, 0, 2'd0, 1, 1, 2'd0, o(0, 0, 1, 1, 0, 0, 0, 2'd2));
    add("d_wd2",   1, 0, 2'd0, 1, 1, 2'd0, o(0, 0, 1, 1, 0, 0, 0, 2'd1));
    add("d_wd3",   0, 0, 2'd0, 1, 1, 2'd0, o(0, 0, 1, 1, 0, 0, 0, 2'd0));
    add("d_wait",  0, 0, 2'd0, 1, 1, 2'd0, o(1, 1, 1, 1, 0, 0, 0, 2'd0));
    add("d_err",   0, 0, 2'd0, 1, 1, 2'd2, o(1, 1, 1, 1, 1, 1, 0, 2'd0));
    add("d_idle",  0, 0, 2'd0, 1, 1, 2'd0, idle_o);

    // Read, len 0, reserved status on the would-be final ACK: error wins, no snapshot.
    add("e_req",   1, 0, 2'd0, 1, 1, 2'd0, o(0, 1, 1, 1, 0, 0, 0, 2'd0));
    add("e_gnt",   0, 0, 2'd0, 0, 1, 2'd0, o(0, 0, 1, 1, 0, 0, 0, 2'd0));
    add("e_addr",  0, 0, 2'd0, 1, 1, 2'd0, o(1, 1, 1, 1, 0, 0, 0, 2'd0));
    add("e_err",   0, 0, 2'd0, 1, 1, 2'd3, o(1, 1, 1, 1, 1, 1, 0, 2'd0));
    add("e_idle",  0, 0, 2'd0, 1, 1, 2'd0, idle_o);

    // Reset state.
    repeat (2) @(posedge b_clk_l);
    #1;
    check("reset_state", obs, rst_o);
    @(negedge b_clk_l);
    reset_l = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Read with no status at all.
    step("f_req",  1, 0, 2'd0, 1, 1, 2'd0, o(0, 1, 1, 1, 0, 0, 0, 2'd0));
    step("f_gnt",  0, 0, 2'd0, 0, 1, 2'd0, o(0, 0, 1, 1, 0, 0, 0, 2'd0));
    step("f_addr", 0, 0, 2'd0, 1, 1, 2'd0, o(1, 1, 1, 1, 0, 0, 0, 2'd0));
    wait_o = o(1, 1, 1, 1, 0, 0, 0, 2'd0);
`ifdef CMI_XFER_TIMEOUT_EN
    for (int j = 1; j < int'(TMO); j++) begin
      step($sformatf("f_wait%0d", j), 0, 0, 2'd0, 1, 1, 2'd0, wait_o);
    end
    step("f_tmo",  0, 0, 2'd0, 1, 1, 2'd0, o(1, 1, 1, 1, 1, 1, 1, 2'd0));
    step("f_idle", 0, 0, 2'd0, 1, 1, 2'd0, idle_o);
`else
    for (int j = 1; j <= 100; j++) begin
      step($sformatf("f_hold%0d", j), 0, 0, 2'd0, 1, 1, 2'd0, wait_o);
    end
    // Leave the stuck WAIT with an asynchronous reset, checked before the next edge.
    #2 reset_l = 1'b0;
    #1 check("f_async_reset", obs, rst_o);
    #2 reset_l = 1'b1;
`endif

    // Write, len 3, reset during the 2nd WDATA cycle, then a fresh read completes.
    step("g_req",  1, 1, 2'd3, 1, 1, 2'd0, o(0, 1, 1, 1, 0, 0, 0, 2'd3));
    step("g_gnt",  0, 0, 2'd0, 0, 1, 2'd0, o(0, 0, 1, 1, 0, 0, 0, 2'd3));
    step("g_wd1",  0, 0, 2'd0, 1, 1, 2'd0, o(0, 0, 1, 1, 0, 0, 0, 2'd3));
    step("g_wd2",  0, 0, 2'd0, 1, 1, 2'd0, o(0, 0, 1, 1, 0, 0, 0, 2'd2));
    #2 reset_l = 1'b0;
    #1 check("g_async_reset", obs, rst_o);
    #2 reset_l = 1'b1;
    step("g2_req",   1, 0, 2'd1, 1, 1, 2'd0, o(0, 1, 1, 1, 0, 0, 0, 2'd1));
    step("g2_gnt",   0, 0, 2'd0, 0, 1, 2'd0, o(0, 0, 1, 1, 0, 0, 0, 2'd1));
    step("g2_addr",  0, 0, 2'd0, 1, 1, 2'd0, o(1, 1, 1, 1, 0, 0, 0, 2'd1));
    step("g2_ack1",  0, 0, 2'd0, 1, 1, 2'd1, o(1, 1, 0, 1, 0, 0, 0, 2'd0));
    step("g2_ack2",  0, 0, 2'd0, 1, 1, 2'd1, o(1, 1, 0, 1, 1, 0, 0, 2'd0));
    step("g2_xack",  0, 0, 2'd0, 1, 1, 2'd1, idle_o);
    step("g2_idle",  0, 0, 2'd0, 1, 1, 2'd0, idle_o);

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_drain: got %0d leftover entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmi_xfer_seq.md
CMI_XFER_SEQ -- requirements
Module: cmi_xfer_seq

Interface
REQ-001 The block SHALL have parameter TMO_MAX, default 31, giving the WAIT-state timeout limit in cycles (range 1..31).
REQ-002 b_clk_l  in  1  system clock; all state updates on its rising edge.
REQ-003 reset_l  in  1  reset, asynchronous, active-low.
REQ-004 req_h  in  1  start a CMI transfer; sampled in IDLE only.
REQ-005 wr_h  in  1  1 = write, 0 = read; latched with req_h.
REQ-006 len_h  in  2  data longwords minus one (0..3 gives 1..4 words); latched with req_h.
REQ-007 cmi_grant_l  in  1  CMI arbitration grant, active-low.
REQ-008 cmi_busy_l  in  1  CMI busy, active-low; a grant is valid only while this input is high.
REQ-009 cmi_stat_h  in  2  slave status: 00 none, 01 ACK/data-valid, 10 error, 11 reserved.
REQ-010 cmi_req_l  out  1  CMI arbitration request, active-low.
REQ-011 ena_cmi_l  out  1  enable for MDR CMI drivers (address/write-data), active-low.
REQ-012 snapshot_cmi_l  out  1  strobe for the MDR read-data latch, active-low.
REQ-013 busy_h  out  1  transfer in progress.
REQ-014 done_h  out  1  one-cycle completion pulse.
REQ-015 err_h  out  1  one-cycle error flag, coincident with done_h.
REQ-016 tmo_h  out  1  qualifies err_h as a timeout.
REQ-017 wcnt_h  out  2  remaining data words minus one.

Function
REQ-018 Every output SHALL be driven from a flop, with no combinational path from any input to any output.
REQ-019 The state machine SHALL have the states IDLE, ARB, ADDR, WDATA, WAIT, DONE and ERR.
REQ-020 In IDLE with req_h=1, the block SHALL latch wr_h, load wcnt_h from len_h, set busy_h and go to ARB; req_h in any other state SHALL be ignored.
REQ-021 In ARB, cmi_req_l=0; the block SHALL go to ADDR when cmi_grant_l=0 and cmi_busy_l=1, and otherwise stay in ARB.
REQ-022 ADDR SHALL last exactly one cycle with ena_cmi_l=0, then go to WDATA if the transfer is a write and to WAIT if it is a read.
REQ-023 In WDATA, ena_cmi_l=0 for exactly wcnt_h+1 cycles; wcnt_h decrements each cycle and the block goes to WAIT after the cycle in which wcnt_h=0; cmi_req_l stays low through WDATA.
REQ-024 On entry to WAIT, cmi_req_l=1 and ena_cmi_l=1, the timeout counter clears, and wcnt_h reloads from the latched length for reads.
REQ-025 Write in WAIT: the first cmi_stat_h=01 SHALL go to DONE.
REQ-026 Read in WAIT: each cmi_stat_h=01 SHALL produce one snapshot_cmi_l=0 cycle on the next cycle, decrement wcnt_h and clear the timeout counter.
REQ-027 Read in WAIT: the ACK sampled when wcnt_h=0 SHALL go to DONE, with its snapshot pulse issued in the DONE cycle.
REQ-028 cmi_stat_h of 10 or 11 in WAIT SHALL go to ERR; when an error status and the final ACK conflict, error wins.
REQ-029 DONE SHALL assert done_h=1 for one cycle; ERR SHALL assert done_h=1 and err_h=1 for one cycle; both go to IDLE and clear busy_h.
REQ-030 wcnt_h SHALL never wrap, and reads SHALL ignore ACKs beyond len_h+1.

Reset
REQ-031 reset_l=0 SHALL force, immediately and from any state (including mid-transfer), state=IDLE, cmi_req_l=1, ena_cmi_l=1, snapshot_cmi_l=1, busy_h=0, done_h=0, err_h=0, tmo_h=0, wcnt_h=0 and timeout counter=0.
REQ-032 After reset_l releases, the first req_h SHALL be accepted on the first rising edge.

Configuration
REQ-033 Macro CMI_XFER_TIMEOUT_EN defined: the 5-bit timeout counter SHALL increment each WAIT cycle without ACK; on reaching TMO_MAX the block goes to ERR with tmo_h=1 for that cycle.
REQ-034 Macro CMI_XFER_TIMEOUT_EN undefined: the counter SHALL be absent, WAIT SHALL hold indefinitely, and tmo_h SHALL be tied to 0.

Verification
REQ-035 Write, len_h=0, grant on the 2nd ARB cycle, ACK 3 cycles later -> ena_cmi_l low for exactly 2 cycles, then done_h=1, err_h=0.
REQ-036 Read, len_h=3, four ACKs with gaps of 0, 2, 0 and 5 cycles -> exactly four snapshot_cmi_l pulses, each 1 cycle after its ACK; done_h coincides with the 4th pulse.
REQ-037 Grant asserted while cmi_busy_l=0 for 4 cycles -> block stays in ARB, ena_cmi_l=1; ADDR follows the 1st cycle with cmi_busy_l=1.
REQ-038 Write, len_h=2, cmi_stat_h=10 in WAIT -> next cycle err_h=1, done_h=1, tmo_h=0, then IDLE.
REQ-039 Read with no status, macro defined, TMO_MAX=31 -> err_h=1 and tmo_h=1 after 31 WAIT cycles; macro undefined -> still busy_h=1 after 100 cycles.
REQ-040 reset_l pulsed low during the 2nd WDATA cycle of a len_h=3 write -> all outputs take reset values before the next edge; a new req_h then completes normally.
